// File: rtl/sub_inst_sched_pkg.sv
// rtl/sub_inst_sched_pkg.sv - shared FSM encoding, defaults and index helper for sub_inst_scheduler
package sub_inst_sched_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_GRANT   = 2'd1,
      ST_RELEASE = 2'd2
   } sched_state_e;

   localparam int N_REQ_DEFAULT    = 5;
   localparam int HOLD_MAX_DEFAULT = 15;

   // Modulo add for offsets in 0..n; avoids a divider for non-power-of-two n.
   function automatic int wrap_add(input int base, input int off, input int n);
      int s;
      s = base + off;
      if (s >= n) s = s - n;
      return s;
   endfunction

endpackage

// File: rtl/sub_inst_scheduler_rr_pick.sv
// rtl/sub_inst_scheduler_rr_pick.sv - combinational round-robin picker: first set req bit after ptr
module rr_pick
   import sub_inst_sched_pkg::*;
#(
   parameter  int N  = N_REQ_DEFAULT,
   localparam int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [IW-1:0] pos;

   // Walk offsets from farthest to nearest so the nearest hit after ptr wins.
   always_comb begin
      idx   = '0;
      found = 1'b0;
      pos   = '0;
      for (int off = N; off >= 1; off--) begin
         pos = IW'(wrap_add(int'(ptr), off, N));
         if (req[pos]) begin
            idx   = pos;
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sub_inst_scheduler.sv
// rtl/sub_inst_scheduler.sv - round-robin single-resource scheduler for N_REQ sub-instances
// Optional forced release after HOLD_MAX grant cycles: define SCHED_HOLD_TIMEOUT_EN.
module sub_inst_scheduler
   import sub_inst_sched_pkg::*;
#(
   parameter  int N_REQ    = N_REQ_DEFAULT,
   parameter  int HOLD_MAX = HOLD_MAX_DEFAULT,
   localparam int IW       = $clog2(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] done,
   output logic [N_REQ-1:0] gnt,
   output logic             gnt_valid,
   output logic [IW-1:0]    gnt_id,
   output logic             busy,
   output logic             timeout
);

   if (N_REQ < 2) begin : g_bad_n_req
      $error("sub_inst_scheduler: N_REQ must be at least 2");
   end
   if (HOLD_MAX < 1) begin : g_bad_hold_max
      $error("sub_inst_scheduler: HOLD_MAX must be at least 1");
   end

   sched_state_e  state_q, state_d;
   logic [IW-1:0] cur_q, cur_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] pick_idx;
   logic          pick_found;
   logic          rel_evt;
   logic          hold_exp;
   logic          to_flag;

   rr_pick #(.N(N_REQ)) u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .idx   (pick_idx),
      .found (pick_found)
   );

   // Only the granted line's done/req matter; other done bits are ignored.
   assign rel_evt = done[cur_q] | ~req[cur_q];

`ifdef SCHED_HOLD_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_MAX + 1);

   logic [CW-1:0] hold_q, hold_d;
   logic          to_q, to_d;

   assign hold_exp = (hold_q == CW'(HOLD_MAX));
   assign to_flag  = to_q;

   // The first GRANT cycle reads 1, so expiry lands after exactly HOLD_MAX grant cycles.
   always_comb begin
      hold_d = hold_q;
      to_d   = 1'b0;
      if (state_q == ST_IDLE && pick_found) begin
         hold_d = CW'(1);
      end else if (state_q == ST_GRANT && !hold_exp) begin
         hold_d = hold_q + CW'(1);
      end
      if (state_q == ST_GRANT && hold_exp && !rel_evt) begin
         to_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         hold_q <= '0;
         to_q   <= 1'b0;
      end else begin
         hold_q <= hold_d;
         to_q   <= to_d;
      end
   end
`else
   assign hold_exp = 1'b0;
   assign to_flag  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (pick_found) state_d = ST_GRANT;
         ST_GRANT:   if (rel_evt || hold_exp) state_d = ST_RELEASE;
         ST_RELEASE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   // ptr only moves on RELEASE, so requests seen mid-grant wait for the next IDLE.
   always_comb begin
      cur_d = cur_q;
      ptr_d = ptr_q;
      if (state_q == ST_IDLE && pick_found) cur_d = pick_idx;
      if (state_q == ST_RELEASE) ptr_d = cur_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cur_q <= '0;
         ptr_q <= IW'(N_REQ - 1);
      end else begin
         cur_q <= cur_d;
         ptr_q <= ptr_d;
      end
   end

   always_comb begin
      gnt       = '0;
      gnt_valid = 1'b0;
      gnt_id    = '0;
      busy      = 1'b0;
      timeout   = 1'b0;
      case (state_q)
         ST_GRANT: begin
            gnt[cur_q] = 1'b1;
            gnt_valid  = 1'b1;
            gnt_id     = cur_q;
            busy       = 1'b1;
         end
         ST_RELEASE: begin
            busy    = 1'b1;
            timeout = to_flag;
         end
         default: ;
      endcase
   end

endmodule

// File: doc/sub_inst_scheduler.md
SUB_INST_SCHEDULER -- requirements
Module: sub_inst_scheduler

Interface
REQ-001 The block SHALL have parameter N_REQ, default 5, meaning the number of sub-instance requesters sharing the resource.
REQ-002 The block SHALL have parameter HOLD_MAX, default 15, meaning the maximum number of GRANT cycles before a forced release.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port req  input  N_REQ  per-requester request, level-sensitive.
REQ-006 The block SHALL have port done  input  N_REQ  per-requester completion, single-cycle pulse.
REQ-007 The block SHALL have port gnt  output  N_REQ  one-hot grant; all zero when idle.
REQ-008 The block SHALL have port gnt_valid  output  1  high exactly when gnt is non-zero.
REQ-009 The block SHALL have port gnt_id  output  $clog2(N_REQ)  index of the granted requester; 0 when not valid.
REQ-010 The block SHALL have port busy  output  1  high in GRANT and RELEASE states.
REQ-011 The block SHALL have port timeout  output  1  single-cycle forced-release pulse.

Function
REQ-012 The FSM SHALL have exactly the states IDLE, GRANT and RELEASE, all registered.
REQ-013 In IDLE with any req bit high, the block SHALL select the first set bit searching from ptr+1 upward, modulo N_REQ.
  - It SHALL then enter GRANT with gnt, gnt_valid and gnt_id registered on the next edge.
  - Latency from req to gnt is one cycle.
REQ-014 In GRANT, gnt SHALL remain stable and one-hot until done[gnt_id]=1 or req[gnt_id]=0.
  - Either event sends the FSM to RELEASE on the next edge.
REQ-015 Bits of done at indices other than gnt_id SHALL be ignored in every state.
REQ-016 RELEASE SHALL last exactly one cycle with gnt=0.
  - In that cycle ptr is loaded with the released index.
  - The FSM then returns to IDLE, giving a minimum two-cycle gap between consecutive grants.
REQ-017 Arbitration SHALL be round-robin: a continuously requesting line is granted within N_REQ grant rounds.
REQ-018 Requests that change while in GRANT or RELEASE SHALL be arbitrated only in the next IDLE cycle.
REQ-019 ptr SHALL wrap from N_REQ-1 to 0.
  - Index arithmetic is modulo N_REQ.
  - Non-power-of-two N_REQ is supported.
REQ-020 A done and a req drop arriving in the same cycle SHALL produce a single RELEASE.

Reset
REQ-021 When rst_n=0 at a clock edge, the block SHALL set FSM=IDLE, ptr=N_REQ-1, gnt=0, gnt_valid=0, gnt_id=0, busy=0, timeout=0 and the hold counter to 0.
REQ-022 A reset asserted during GRANT SHALL drop gnt on that same edge, with no RELEASE cycle.
  - After reset deassertion, requester 0 has highest priority.

Configuration
REQ-023 With macro SCHED_HOLD_TIMEOUT_EN defined, a hold counter SHALL count GRANT cycles from 1.
  - When it reaches HOLD_MAX without release, the FSM enters RELEASE and timeout pulses high for that RELEASE cycle.
  - The counter clears on entry to GRANT.
REQ-024 Without SCHED_HOLD_TIMEOUT_EN, the counter SHALL NOT be synthesized, timeout is tied to 0, and a grant may be held indefinitely.

Structure
REQ-025 A shared package sub_inst_sched_pkg SHALL hold the FSM state enum and the N_REQ default constant.
REQ-026 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs idx and found), instantiated once.

Verification
REQ-027 Reset, then req=5'b00101 held -> gnt=00001 one cycle later; after done[0], RELEASE, then gnt=00100.
REQ-028 All five req held, each done pulsed two cycles after its grant -> grant order 0,1,2,3,4,0 with a 2-cycle gap between grants.
REQ-029 During gnt=00010, pulse done[3] -> gnt unchanged, no RELEASE.
REQ-030 With SCHED_HOLD_TIMEOUT_EN and HOLD_MAX=15, req[2] held with no done -> gnt drops after 15 GRANT cycles and timeout is high for 1 cycle; without the macro -> gnt is held for 100+ cycles and timeout stays 0.
REQ-031 rst_n=0 during GRANT of requester 3 -> gnt=0 on that edge; after release with req=5'b11111, first grant is to requester 0.
REQ-032 req[1] deasserted at the same edge as done[1] -> exactly one RELEASE cycle, then arbitration of the remaining requests.
